// File: rtl/multicycle_control.sv
// multicycle_control: sequences each MIPS instruction through fetch, decode,
// execute, memory and write-back steps over a single shared memory port.
// Control outputs are decoded from the current state. The FETCH strobes and
// the MEM exit also follow mem_ready in the same cycle.
module multicycle_control #(
  parameter int OPW     = 6,
  parameter int FUNCTW  = 6,
  parameter int ALUCTLW = 4,
  parameter int CNTW    = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [OPW-1:0]     opcode,
  input  logic [FUNCTW-1:0]  funct,
  input  logic               mem_ready,
  output logic               mem_req,
  output logic               mem_we,
  output logic               iord,
  output logic               ir_write,
  output logic               pc_write,
  output logic               pc_write_eq,
  output logic               pc_write_ne,
  output logic [1:0]         pc_src,
  output logic               alusrc_a,
  output logic [1:0]         alusrc_b,
  output logic [ALUCTLW-1:0] aluctl,
  output logic               regdst,
  output logic               regwrite,
  output logic               memtoreg,
  output logic               illegal_op,
  output logic [CNTW-1:0]    instret,
  output logic [3:0]         state
);

  localparam logic [5:0] OP_LW    = 6'b000011;
  localparam logic [5:0] OP_SW    = 6'b001011;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_SUBI  = 6'b011000;
  localparam logic [5:0] OP_RTYPE = 6'b100010;
  localparam logic [5:0] OP_BEQ   = 6'b110100;
  localparam logic [5:0] OP_BNE   = 6'b110101;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [3:0] S_FETCH  = 4'd0;
  localparam logic [3:0] S_DECODE = 4'd1;
  localparam logic [3:0] S_ADDR   = 4'd2;
  localparam logic [3:0] S_MEM    = 4'd3;
  localparam logic [3:0] S_MEMWB  = 4'd4;
  localparam logic [3:0] S_EXEC_I = 4'd5;
  localparam logic [3:0] S_WB_I   = 4'd6;
  localparam logic [3:0] S_EXEC_R = 4'd7;
  localparam logic [3:0] S_WB_R   = 4'd8;
  localparam logic [3:0] S_BRANCH = 4'd9;
  localparam logic [3:0] S_JUMP   = 4'd10;

  localparam logic [ALUCTLW-1:0] ALU_ADD = ALUCTLW'(2);
  localparam logic [ALUCTLW-1:0] ALU_SUB = ALUCTLW'(6);

  logic [3:0]      state_q, state_d;
  logic [CNTW-1:0] instret_q, instret_d;
  logic            retire;

  logic [5:0] op_lo;
  logic       op_hi_zero;
  logic       is_lw, is_sw, is_addi, is_subi, is_rtype, is_beq, is_bne, is_j;
  logic       is_legal;
  logic       unused_funct;

  // An opcode only matches when every bit above the low six is clear.
  assign op_lo      = opcode[5:0];
  assign op_hi_zero = ((opcode >> 6) == '0);
  assign is_lw      = op_hi_zero && (op_lo == OP_LW);
  assign is_sw      = op_hi_zero && (op_lo == OP_SW);
  assign is_addi    = op_hi_zero && (op_lo == OP_ADDI);
  assign is_subi    = op_hi_zero && (op_lo == OP_SUBI);
  assign is_rtype   = op_hi_zero && (op_lo == OP_RTYPE);
  assign is_beq     = op_hi_zero && (op_lo == OP_BEQ);
  assign is_bne     = op_hi_zero && (op_lo == OP_BNE);
  assign is_j       = op_hi_zero && (op_lo == OP_J);
  assign is_legal   = is_lw | is_sw | is_addi | is_subi | is_rtype |
                      is_beq | is_bne | is_j;

  // The upper funct bits never reach the ALU control.
  assign unused_funct = ^funct;

  assign instret = instret_q;
  assign state   = state_q;

  // Next-state selection and detection of the edge that retires an instruction.
  always_comb begin
    state_d = state_q;
    retire  = 1'b0;
    case (state_q)
      S_FETCH: begin
        if (mem_ready) state_d = S_DECODE;
      end
      S_DECODE: begin
        if (is_lw || is_sw)          state_d = S_ADDR;
        else if (is_addi || is_subi) state_d = S_EXEC_I;
        else if (is_rtype)           state_d = S_EXEC_R;
        else if (is_beq || is_bne)   state_d = S_BRANCH;
        else if (is_j)               state_d = S_JUMP;
        else                         state_d = S_FETCH;
      end
      S_ADDR:   state_d = S_MEM;
      S_MEM: begin
        if (mem_ready) begin
          if (is_sw) begin
            state_d = S_FETCH;
            retire  = 1'b1;
          end else begin
            state_d = S_MEMWB;
          end
        end
      end
      S_EXEC_I: state_d = S_WB_I;
      S_EXEC_R: state_d = S_WB_R;
      S_MEMWB, S_WB_I, S_WB_R, S_BRANCH, S_JUMP: begin
        state_d = S_FETCH;
        retire  = 1'b1;
      end
      default:  state_d = S_FETCH;
    endcase
    instret_d = instret_q + CNTW'(retire);
  end

  // State and retire counter; reset wins over a retire in the same cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_FETCH;
      instret_q <= '0;
    end else begin
      state_q   <= state_d;
      instret_q <= instret_d;
    end
  end

  // Control outputs per state, all held low while reset is asserted.
  always_comb begin
    mem_req     = 1'b0;
    mem_we      = 1'b0;
    iord        = 1'b0;
    ir_write    = 1'b0;
    pc_write    = 1'b0;
    pc_write_eq = 1'b0;
    pc_write_ne = 1'b0;
    pc_src      = 2'd0;
    alusrc_a    = 1'b0;
    alusrc_b    = 2'd0;
    aluctl      = '0;
    regdst      = 1'b0;
    regwrite    = 1'b0;
    memtoreg    = 1'b0;
    illegal_op  = 1'b0;
    if (!rst) begin
      case (state_q)
        S_FETCH: begin
          mem_req  = 1'b1;
          alusrc_b = 2'd1;
          aluctl   = ALU_ADD;
          ir_write = mem_ready;
          pc_write = mem_ready;
        end
        S_DECODE: begin
          alusrc_b   = 2'd3;
          aluctl     = ALU_ADD;
          illegal_op = ~is_legal;
        end
        S_ADDR: begin
          alusrc_a = 1'b1;
          alusrc_b = 2'd2;
          aluctl   = ALU_ADD;
        end
        S_MEM: begin
          mem_req = 1'b1;
          iord    = 1'b1;
          mem_we  = is_sw;
        end
        S_MEMWB: begin
          regwrite = 1'b1;
          memtoreg = 1'b1;
        end
        S_EXEC_I: begin
          alusrc_a = 1'b1;
          alusrc_b = 2'd2;
          aluctl   = is_subi ? ALU_SUB : ALU_ADD;
        end
        S_WB_I: begin
          regwrite = 1'b1;
        end
        S_EXEC_R: begin
          alusrc_a = 1'b1;
          aluctl   = funct[ALUCTLW-1:0];
        end
        S_WB_R: begin
          regwrite = 1'b1;
          regdst   = 1'b1;
        end
        S_BRANCH: begin
          alusrc_a    = 1'b1;
          aluctl      = ALU_SUB;
          pc_src      = 2'd1;
          pc_write_eq = is_beq;
          pc_write_ne = is_bne;
        end
        S_JUMP: begin
          pc_write = 1'b1;
          pc_src   = 2'd2;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_multicycle_control.sv
// Testbench for multicycle_control: each instruction is expanded into its
// route of named steps, the expected controls per step are looked up from a
// table and compared every cycle together with the retired-instruction count.
module tb_multicycle_control;

   localparam logic [5:0] LW    = 6'b000011;
   localparam logic [5:0] SW    = 6'b001011;
   localparam logic [5:0] ADDI  = 6'b001000;
   localparam logic [5:0] SUBI  = 6'b011000;
   localparam logic [5:0] RTYPE = 6'b100010;
   localparam logic [5:0] BEQ   = 6'b110100;
   localparam logic [5:0] BNE   = 6'b110101;
   localparam logic [5:0] JMP   = 6'b000010;

   typedef struct packed {
      logic       memReq;
      logic       memWe;
      logic       iord;
      logic       irWrite;
      logic       pcWrite;
      logic       pcWriteEq;
      logic       pcWriteNe;
      logic [1:0] pcSrc;
      logic       aluSrcA;
      logic [1:0] aluSrcB;
      logic [3:0] aluCtl;
      logic       regDst;
      logic       regWrite;
      logic       memToReg;
      logic       illegalOp;
   } ctl_t;

   logic       clk;
   logic       rst;
   logic [5:0] opcode;
   logic [5:0] funct;
   logic       mem_ready;
   logic       mem_req, mem_we, iord, ir_write, pc_write, pc_write_eq, pc_write_ne;
   logic [1:0] pc_src;
   logic       alusrc_a;
   logic [1:0] alusrc_b;
   logic [3:0] aluctl;
   logic       regdst, regwrite, memtoreg, illegal_op;
   logic [3:0] instret;
   logic [3:0] state;
   logic [19:0] actBits;

   int errorCount = 0;
   int checkCount = 0;
   int expRet = 0;

   multicycle_control #(.OPW(6), .FUNCTW(6), .ALUCTLW(4), .CNTW(4)) dut (
      .clk(clk), .rst(rst), .opcode(opcode), .funct(funct), .mem_ready(mem_ready),
      .mem_req(mem_req), .mem_we(mem_we), .iord(iord), .ir_write(ir_write),
      .pc_write(pc_write), .pc_write_eq(pc_write_eq), .pc_write_ne(pc_write_ne),
      .pc_src(pc_src), .alusrc_a(alusrc_a), .alusrc_b(alusrc_b), .aluctl(aluctl),
      .regdst(regdst), .regwrite(regwrite), .memtoreg(memtoreg),
      .illegal_op(illegal_op), .instret(instret), .state(state)
   );

   assign actBits = {mem_req, mem_we, iord, ir_write, pc_write, pc_write_eq,
                     pc_write_ne, pc_src, alusrc_a, alusrc_b, aluctl, regdst,
                     regwrite, memtoreg, illegal_op};

   // Free-running clock.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Counts one comparison and reports it when it differs.
   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checkCount++;
      if (obs !== exp) begin
         errorCount++;
         $display("[TB] FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic bit isLegal(input logic [5:0] op);
      case (op)
         LW, SW, ADDI, SUBI, RTYPE, BEQ, BNE, JMP: return 1'b1;
         default:                                 return 1'b0;
      endcase
   endfunction

   // Expected control word for one named step of an instruction.
   function automatic ctl_t ctlOf(input string stepName, input logic ready,
                                  input logic [5:0] op, input logic [5:0] fn);
      ctl_t c;
      c = '0;
      case (stepName)
         "FETCH": begin
            c.memReq = 1'b1; c.aluSrcB = 2'd1; c.aluCtl = 4'd2;
            c.irWrite = ready; c.pcWrite = ready;
         end
         "DECODE": begin
            c.aluSrcB = 2'd3; c.aluCtl = 4'd2; c.illegalOp = !isLegal(op);
         end
         "ADDR":   begin c.aluSrcA = 1'b1; c.aluSrcB = 2'd2; c.aluCtl = 4'd2; end
         "MEM":    begin c.memReq = 1'b1; c.iord = 1'b1; c.memWe = (op == SW); end
         "MEMWB":  begin c.regWrite = 1'b1; c.memToReg = 1'b1; end
         "EXEC_I": begin
            c.aluSrcA = 1'b1; c.aluSrcB = 2'd2; c.aluCtl = (op == SUBI) ? 4'd6 : 4'd2;
         end
         "WB_I":   c.regWrite = 1'b1;
         "EXEC_R": begin c.aluSrcA = 1'b1; c.aluCtl = fn[3:0]; end
         "WB_R":   begin c.regWrite = 1'b1; c.regDst = 1'b1; end
         "BRANCH": begin
            c.aluSrcA = 1'b1; c.aluCtl = 4'd6; c.pcSrc = 2'd1;
            c.pcWriteEq = (op == BEQ); c.pcWriteNe = (op == BNE);
         end
         "JUMP":   begin c.pcWrite = 1'b1; c.pcSrc = 2'd2; end
         default: ;
      endcase
      return c;
   endfunction

   // Runs one instruction through its route; abortAt >= 0 asserts reset at that step.
   task automatic applyStimulus(input string tag, input logic [5:0] op, input logic [5:0] fn,
                                input int fetchWaits, input int memWaits, input int abortAt);
      string names[$];
      bit    readies[$];
      for (int k = 0; k < fetchWaits; k++) begin names.push_back("FETCH"); readies.push_back(1'b0); end
      names.push_back("FETCH");  readies.push_back(1'b1);
      names.push_back("DECODE"); readies.push_back(1'($urandom_range(0, 1)));
      case (op)
         LW, SW: begin
            names.push_back("ADDR"); readies.push_back(1'($urandom_range(0, 1)));
            for (int k = 0; k < memWaits; k++) begin names.push_back("MEM"); readies.push_back(1'b0); end
            names.push_back("MEM"); readies.push_back(1'b1);
            if (op == LW) begin names.push_back("MEMWB"); readies.push_back(1'($urandom_range(0, 1))); end
         end
         ADDI, SUBI: begin
            names.push_back("EXEC_I"); readies.push_back(1'($urandom_range(0, 1)));
            names.push_back("WB_I");   readies.push_back(1'($urandom_range(0, 1)));
         end
         RTYPE: begin
            names.push_back("EXEC_R"); readies.push_back(1'($urandom_range(0, 1)));
            names.push_back("WB_R");   readies.push_back(1'($urandom_range(0, 1)));
         end
         BEQ, BNE: begin names.push_back("BRANCH"); readies.push_back(1'($urandom_range(0, 1))); end
         JMP:      begin names.push_back("JUMP");   readies.push_back(1'($urandom_range(0, 1))); end
         default: ;
      endcase
      for (int i = 0; i < names.size(); i++) begin
         @(negedge clk);
         if (i == 0) begin opcode = op; funct = fn; end
         if (i == abortAt) begin
            rst = 1'b1;
            mem_ready = 1'($urandom_range(0, 1));
            #1;
            checkOutput({tag, ":rstCtl"}, 32'(actBits), 32'(0));
            checkOutput({tag, ":rstInstretBefore"}, 32'(instret), 32'(expRet));
            @(posedge clk);
            #1;
            rst = 1'b0;
            expRet = 0;
            checkOutput({tag, ":rstInstretAfter"}, 32'(instret), 32'(0));
            return;
         end
         mem_ready = readies[i];
         #1;
         checkOutput({tag, ":", names[i]}, 32'(actBits), 32'(ctlOf(names[i], readies[i], op, fn)));
         checkOutput({tag, ":instret"}, 32'(instret), 32'(expRet));
      end
      if (isLegal(op)) expRet = (expRet + 1) % 16;
   endtask

   logic [5:0] opTable [10];

   // Main sequence: reset, directed instructions, random mix, reset aborts.
   initial begin
      logic [5:0] fn;
      opTable[0] = LW;   opTable[1] = SW;  opTable[2] = ADDI; opTable[3] = SUBI;
      opTable[4] = RTYPE; opTable[5] = BEQ; opTable[6] = BNE; opTable[7] = JMP;
      opTable[8] = 6'b111111; opTable[9] = 6'b000000;

      rst = 1'b1;
      mem_ready = 1'b1;
      opcode = '0;
      funct = '0;
      for (int k = 0; k < 2; k++) begin
         @(negedge clk);
         #1;
         checkOutput("resetCtl", 32'(actBits), 32'(0));
         checkOutput("resetInstret", 32'(instret), 32'(0));
      end
      @(posedge clk);
      #1;
      rst = 1'b0;
      expRet = 0;

      applyStimulus("lw",      LW,    6'b010101, 0, 0, -1);
      applyStimulus("swWait",  SW,    6'b000000, 0, 3, -1);
      applyStimulus("rtype",   RTYPE, 6'b100100, 0, 0, -1);
      applyStimulus("subi",    SUBI,  6'b111111, 1, 0, -1);
      applyStimulus("addi",    ADDI,  6'b000110, 0, 0, -1);
      applyStimulus("beq",     BEQ,   6'b000000, 0, 0, -1);
      applyStimulus("bne",     BNE,   6'b000000, 2, 0, -1);
      applyStimulus("j",       JMP,   6'b000000, 0, 0, -1);
      applyStimulus("illegal", 6'b111111, 6'b000000, 0, 0, -1);

      for (int n = 0; n < 24; n++) begin
         fn = 6'($urandom);
         applyStimulus("rand", opTable[$urandom_range(0, 9)], fn,
                       $urandom_range(0, 2), $urandom_range(0, 3), -1);
      end

      applyStimulus("lwAbortMem",  LW,   6'b000000, 0, 2, 4);
      applyStimulus("afterAbort",  JMP,  6'b000000, 0, 0, -1);
      applyStimulus("addiAbortWb", ADDI, 6'b000000, 0, 0, 3);
      applyStimulus("final",       RTYPE, 6'b001010, 0, 0, -1);

      $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
      $finish;
   end

endmodule

// File: doc/multicycle_control.md
# multicycle_control

Multicycle control unit for the MIPS core: a Moore/Mealy FSM that sequences each instruction through fetch, decode, execute, memory and write-back steps over a shared memory port. It generalises the single-cycle opcode decoder with parametrised opcode, funct and ALU-control widths. It also adds a memory ready/request handshake with arbitrary wait states, an illegal-opcode indication and a retired-instruction counter. It sits between the instruction register and the datapath multiplexers, register file and memory interface.

## Interface
- `OPW`, 6, opcode width; the encodings below occupy the low 6 bits, and any upper bits must be 0.
- `FUNCTW`, 6, R-type funct field width.
- `ALUCTLW`, 4, ALU control width (≥ 4); R-type passes `funct[ALUCTLW-1:0]`.
- `CNTW`, 32, retired-instruction counter width.
- `clk`  in  1  clock; all state changes on the rising edge.
- `rst`  in  1  reset; synchronous, active-high.
- `opcode`  in  OPW  from the instruction register; valid from DECODE onward.
- `funct`  in  FUNCTW  from the instruction register.
- `mem_ready`  in  1  memory completes the current request this cycle.
- `mem_req`, `mem_we`, `iord`  out  1 each  memory request, write enable, address select (0 = PC, 1 = ALU out).
- `ir_write`, `pc_write`, `pc_write_eq`, `pc_write_ne`  out  1 each  IR load, unconditional PC load, PC load if zero, PC load if not zero.
- `pc_src`  out  2  0 = ALU result, 1 = ALU out register, 2 = jump target.
- `alusrc_a`  out  1  0 = PC, 1 = rs.
- `alusrc_b`  out  2  0 = rt, 1 = constant 4, 2 = sign-extended immediate, 3 = sign-extended immediate << 2.
- `aluctl`  out  ALUCTLW  2 = add, 6 = subtract, else funct.
- `regdst`, `regwrite`, `memtoreg`  out  1 each  register-file controls.
- `illegal_op`  out  1  one-cycle pulse on an unknown opcode.
- `instret`  out  CNTW  count of retired instructions.
- `state`  out  4  current state encoding, for debug.

## Operation
- Opcodes (low 6 bits): lw `000011`, sw `001011`, addi `001000`, subi `011000`, R-type `100010`, beq `110100`, bne `110101`, j `000010`.
- **FETCH**: mem_req=1, iord=0, alusrc_a=0, alusrc_b=1, aluctl=2.
  - When mem_ready=1: ir_write=1, pc_write=1, pc_src=0, then go to DECODE.
  - Otherwise stay in FETCH with ir_write and pc_write held at 0.
- **DECODE**: alusrc_a=0, alusrc_b=3, aluctl=2 (branch target into the ALU out register). Next state by opcode:
  - lw/sw → ADDR
  - addi/subi → EXEC_I
  - R-type → EXEC_R
  - beq/bne → BRANCH
  - j → JUMP
  - any other opcode → FETCH, with illegal_op=1 for this one cycle.
- **ADDR**: alusrc_a=1, alusrc_b=2, aluctl=2, then go to MEM.
- **MEM**: mem_req=1, iord=1, mem_we=1 for sw only.
  - Hold in MEM until mem_ready=1.
  - Then lw → MEMWB; sw → FETCH (retire).
- **MEMWB**: regwrite=1, memtoreg=1, regdst=0, then go to FETCH (retire).
- **EXEC_I**: alusrc_a=1, alusrc_b=2, aluctl=2 for addi or 6 for subi, then go to WB_I.
- **WB_I**: regwrite=1, regdst=0, then go to FETCH (retire).
- **EXEC_R**: alusrc_a=1, alusrc_b=0, aluctl=funct[ALUCTLW-1:0] zero-extended, then go to WB_R.
- **WB_R**: regwrite=1, regdst=1, then go to FETCH (retire).
- **BRANCH**: alusrc_a=1, alusrc_b=0, aluctl=6, pc_src=1, pc_write_eq=1 for beq or pc_write_ne=1 for bne, then go to FETCH (retire).
- **JUMP**: pc_write=1, pc_src=2, then go to FETCH (retire).
- Any output not listed for a state is 0.
- `instret` increments by 1 on the clock edge leaving a retiring state. It wraps modulo 2^CNTW. Illegal opcodes do not count.

## Timing
- Outputs are combinational from the state. ir_write and pc_write in FETCH, and the MEM exit, also depend on mem_ready in the same cycle (Mealy).
- Cycles per instruction at zero wait states (mem_ready high in the request cycle):
  - lw: 5
  - sw, addi/subi, R-type: 4
  - beq/bne, j: 3
  - illegal opcode: 2
- Each wait cycle of mem_ready=0 adds 1 cycle in FETCH or MEM. There is no timeout.
- Reset:
  - rst=1 at an edge sets state=FETCH and instret=0, including mid-instruction; a memory request in flight is abandoned.
  - While rst=1, all control outputs and illegal_op are forced to 0.
  - First mem_req=1 appears in the first cycle after rst deasserts.
- Opcode and funct must stay stable from DECODE until the instruction retires. ir_write only pulses in FETCH.
- A retire and a rst edge in the same cycle: rst wins, and instret becomes 0.

## Test plan
- Reset, then lw with mem_ready held at 1 → state sequence FETCH, DECODE, ADDR, MEM, MEMWB; regwrite=memtoreg=1 only in MEMWB; instret=1 after 5 cycles.
- sw with mem_ready=0 for 3 cycles in MEM → mem_req=iord=mem_we=1 held for 4 cycles; regwrite never 1; total 7 cycles.
- R-type with funct=`100100` → aluctl=4 in EXEC_R, then regdst=regwrite=1; subi → aluctl=6; addi → aluctl=2.
- beq then bne → pc_write_eq=1 (respectively pc_write_ne=1) with pc_src=1 in BRANCH only; j → pc_write=1 with pc_src=2; 3 cycles each.
- Opcode `111111` → illegal_op pulses exactly 1 cycle in DECODE, FSM returns to FETCH, instret unchanged.
- CNTW=4: retire 17 instructions → instret=1 (wrap). rst asserted in MEM with mem_req=1 → next cycle all outputs 0 and instret=0; after release, FETCH with mem_req=1.
